// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input path: bank count and the generic
// bit-reversal used to scatter samples into butterfly order.
package fft_pkg;

    localparam int NUM_BANKS = 2;
    localparam int MAX_AWL   = 16;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_AWL-1:0] bit_rev(input logic [MAX_AWL-1:0] v,
                                                   input int unsigned         w);
        logic [MAX_AWL-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_AWL; i++) begin
            r[i] = v[MAX_AWL-1-i];
        end
        return r >> (MAX_AWL - w);
    endfunction

endpackage

// File: rtl/in_fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable. The read register holds its value while re is low.
module in_fft_sdp_ram #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // NOTE: storage and the read register have no reset so the array maps onto
    // block RAM; the declaration initialisers only give simulation a clean start.
    logic [DW-1:0] mem [2**AW] = '{default: '0};
    logic [DW-1:0] q = '0;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            q <= mem[rd_addr];
        end
    end

    assign rd_data = q;

endmodule

// File: rtl/in_fft_pingpong_buffer.sv
// Ping-pong complex input frame buffer: the writer fills one bank (optionally in
// bit-reversed order) while the butterfly engine drains the other as (2k, 2k+1) pairs.
module in_fft_pingpong_buffer
    import fft_pkg::*;
#(
    parameter int DWL              = 16,
    parameter int AWL              = 8,
    parameter int BIT_REVERS_WRITE = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           WR_INC,
    input  logic [DWL-1:0] WR_DATA_R,
    input  logic [DWL-1:0] WR_DATA_I,
    output logic           WR_FULL,
    input  logic           R_INC,
    output logic           R_EMPTY,
    output logic           R_VALID,
    output logic           R_LAST,
    output logic [DWL-1:0] R_DATA_1_R,
    output logic [DWL-1:0] R_DATA_1_I,
    output logic [DWL-1:0] R_DATA_2_R,
    output logic [DWL-1:0] R_DATA_2_I,
    output logic [1:0]     FRAMES_READY
);

    logic                 wb;
    logic                 rb;
    logic [NUM_BANKS-1:0] bank_full;
    logic [NUM_BANKS-1:0] bank_full_nxt;
    logic [AWL-1:0]       wr_cnt;
    logic [AWL-2:0]       pair_cnt;
    logic                 r_valid_q;
    logic                 r_last_q;
    logic                 data_ok;

    logic           en_wr;
    logic           en_r;
    logic           wr_last;
    logic           rd_last;
    logic [AWL-1:0] wr_addr;
    logic [AWL-1:0] ram_wr_addr;
    logic [AWL-1:0] ram_rd_addr;
    logic           we_even;
    logic           we_odd;

    logic [DWL-1:0] q_even_r;
    logic [DWL-1:0] q_even_i;
    logic [DWL-1:0] q_odd_r;
    logic [DWL-1:0] q_odd_i;

    assign WR_FULL      = bank_full[wb];
    assign R_EMPTY      = !bank_full[rb];
    assign FRAMES_READY = 2'(bank_full[0]) + 2'(bank_full[1]);

    assign en_wr   = WR_INC && !WR_FULL;
    assign en_r    = R_INC && !R_EMPTY;
    assign wr_last = &wr_cnt;
    assign rd_last = &pair_cnt;

    assign wr_addr = (BIT_REVERS_WRITE != 0) ? AWL'(bit_rev(MAX_AWL'(wr_cnt), AWL)) : wr_cnt;

    // The address LSB picks the RAM, so a pair read touches each RAM exactly once.
    assign ram_wr_addr = {wb, wr_addr[AWL-1:1]};
    assign ram_rd_addr = {rb, pair_cnt};
    assign we_even     = en_wr && !wr_addr[0];
    assign we_odd      = en_wr &&  wr_addr[0];

    // Close and release always hit different banks, so both may apply together.
    always_comb begin
        // NOTE: default first so every path assigns the vector and no latch is inferred.
        bank_full_nxt = bank_full;
        if (en_wr && wr_last) begin
            bank_full_nxt[wb] = 1'b1;
        end
        if (en_r && rd_last) begin
            bank_full_nxt[rb] = 1'b0;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb        <= 1'b0;
            rb        <= 1'b0;
            bank_full <= '0;
            wr_cnt    <= '0;
            pair_cnt  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            data_ok   <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            r_valid_q <= en_r;
            r_last_q  <= en_r && rd_last;
            if (en_wr) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wb <= ~wb;
                end
            end
            if (en_r) begin
                pair_cnt <= pair_cnt + 1'b1;
                data_ok  <= 1'b1;
                if (rd_last) begin
                    rb <= ~rb;
                end
            end
        end
    end

    in_fft_sdp_ram #(.DW(DWL), .AW(AWL)) u_even_r (
        .CLK(CLK), .we(we_even), .wr_addr(ram_wr_addr), .wr_data(WR_DATA_R),
        .re(en_r), .rd_addr(ram_rd_addr), .rd_data(q_even_r)
    );

    in_fft_sdp_ram #(.DW(DWL), .AW(AWL)) u_even_i (
        .CLK(CLK), .we(we_even), .wr_addr(ram_wr_addr), .wr_data(WR_DATA_I),
        .re(en_r), .rd_addr(ram_rd_addr), .rd_data(q_even_i)
    );

    in_fft_sdp_ram #(.DW(DWL), .AW(AWL)) u_odd_r (
        .CLK(CLK), .we(we_odd), .wr_addr(ram_wr_addr), .wr_data(WR_DATA_R),
        .re(en_r), .rd_addr(ram_rd_addr), .rd_data(q_odd_r)
    );

    in_fft_sdp_ram #(.DW(DWL), .AW(AWL)) u_odd_i (
        .CLK(CLK), .we(we_odd), .wr_addr(ram_wr_addr), .wr_data(WR_DATA_I),
        .re(en_r), .rd_addr(ram_rd_addr), .rd_data(q_odd_i)
    );

    // The RAM read registers cannot be reset, so the data outputs are gated to
    // zero until the first read after reset.
    assign R_VALID    = r_valid_q;
    assign R_LAST     = r_last_q;
    assign R_DATA_1_R = data_ok ? q_even_r : '0;
    assign R_DATA_1_I = data_ok ? q_even_i : '0;
    assign R_DATA_2_R = data_ok ? q_odd_r  : '0;
    assign R_DATA_2_I = data_ok ? q_odd_i  : '0;

endmodule

// File: tb/tb_in_fft_pingpong_buffer.sv
// Checks a bit-reversing and a linear instance side by side against a frame-queue
// model, plus literal expectations for the directed scenarios.
module tb_in_fft_pingpong_buffer;

    localparam int DWL = 16;
    localparam int AWL = 3;
    localparam int N   = 8;
    localparam int NP  = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           WR_INC = 1'b0;
    logic           R_INC = 1'b0;
    logic [DWL-1:0] WR_DATA_R = '0;
    logic [DWL-1:0] WR_DATA_I = '0;

    logic           b_full, b_empty, b_valid, b_last;
    logic [DWL-1:0] b_1r, b_1i, b_2r, b_2i;
    logic [1:0]     b_fr;
    logic           l_full, l_empty, l_valid, l_last;
    logic [DWL-1:0] l_1r, l_1i, l_2r, l_2i;
    logic [1:0]     l_fr;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    in_fft_pingpong_buffer #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_WRITE(1)) dut_br (
        .CLK(CLK), .RST(RST), .WR_INC(WR_INC), .WR_DATA_R(WR_DATA_R), .WR_DATA_I(WR_DATA_I),
        .WR_FULL(b_full), .R_INC(R_INC), .R_EMPTY(b_empty), .R_VALID(b_valid), .R_LAST(b_last),
        .R_DATA_1_R(b_1r), .R_DATA_1_I(b_1i), .R_DATA_2_R(b_2r), .R_DATA_2_I(b_2i),
        .FRAMES_READY(b_fr)
    );

    in_fft_pingpong_buffer #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_WRITE(0)) dut_lin (
        .CLK(CLK), .RST(RST), .WR_INC(WR_INC), .WR_DATA_R(WR_DATA_R), .WR_DATA_I(WR_DATA_I),
        .WR_FULL(l_full), .R_INC(R_INC), .R_EMPTY(l_empty), .R_VALID(l_valid), .R_LAST(l_last),
        .R_DATA_1_R(l_1r), .R_DATA_1_I(l_1i), .R_DATA_2_R(l_2r), .R_DATA_2_I(l_2i),
        .FRAMES_READY(l_fr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of complete frames ----------------
    typedef logic [31:0] frame_t [N];
    frame_t      frames[$];
    frame_t      cur;
    int          wcnt = 0;
    int          rcnt = 0;
    logic        m_valid = 1'b0;
    logic        m_last  = 1'b0;
    logic [31:0] mb1 = '0, mb2 = '0, ml1 = '0, ml2 = '0;

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < AWL; i++) begin
            if (v[i]) r |= 1 << (AWL - 1 - i);
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        logic acc_w, acc_r;
        int   p0;
        if (!RST) begin
            frames.delete();
            wcnt = 0; rcnt = 0;
            m_valid = 1'b0; m_last = 1'b0;
            mb1 = '0; mb2 = '0; ml1 = '0; ml2 = '0;
        end else begin
            acc_w = WR_INC && (frames.size() < 2);
            acc_r = R_INC && (frames.size() > 0);
            m_valid = acc_r;
            m_last  = acc_r && (rcnt == NP - 1);
            if (acc_r) begin
                p0  = 2 * rcnt;
                mb1 = frames[0][rev(p0)];
                mb2 = frames[0][rev(p0 + 1)];
                ml1 = frames[0][p0];
                ml2 = frames[0][p0 + 1];
                rcnt++;
                if (rcnt == NP) begin
                    rcnt = 0;
                    void'(frames.pop_front());
                end
            end
            if (acc_w) begin
                cur[wcnt] = {WR_DATA_R, WR_DATA_I};
                wcnt++;
                if (wcnt == N) begin
                    frames.push_back(cur);
                    wcnt = 0;
                end
            end
        end
        #1;
        check("br_full",   b_full,  frames.size() == 2);
        check("br_empty",  b_empty, frames.size() == 0);
        check("br_frames", b_fr,    frames.size());
        check("br_valid",  b_valid, m_valid);
        check("br_last",   b_last,  m_last);
        check("br_d1",     {b_1r, b_1i}, mb1);
        check("br_d2",     {b_2r, b_2i}, mb2);
        check("lin_full",  l_full,  frames.size() == 2);
        check("lin_empty", l_empty, frames.size() == 0);
        check("lin_frames", l_fr,   frames.size());
        check("lin_valid", l_valid, m_valid);
        check("lin_last",  l_last,  m_last);
        check("lin_d1",    {l_1r, l_1i}, ml1);
        check("lin_d2",    {l_2r, l_2i}, ml2);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic wi, input logic [15:0] dr, input logic [15:0] di,
                        input logic ri);
        WR_INC = wi; WR_DATA_R = dr; WR_DATA_I = di; R_INC = ri;
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        WR_INC = 1'b0; R_INC = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"},  {b_full, l_full},   2'b00);
        check({tag, "_empty"}, {b_empty, l_empty}, 2'b11);
        check({tag, "_valid"}, {b_valid, l_valid}, 2'b00);
        check({tag, "_last"},  {b_last, l_last},   2'b00);
        check({tag, "_frames"}, {b_fr, l_fr},      4'h0);
        check({tag, "_data_br"},  {b_1r, b_1i, b_2r, b_2i} == '0, 1'b1);
        check({tag, "_data_lin"}, {l_1r, l_1i, l_2r, l_2i} == '0, 1'b1);
    endtask

    int lit_b1[4] = '{0, 2, 1, 3};
    int lit_b2[4] = '{4, 6, 5, 7};
    int lit_l1[4] = '{0, 2, 4, 6};
    int lit_l2[4] = '{1, 3, 5, 7};

    task automatic write_frame(input int base);
        for (int k = 0; k < N; k++) step(1'b1, 16'(base + k), 16'(base + k + 8), 1'b0);
    endtask

    task automatic read_frame_literal(input int base, input string tag);
        for (int i = 0; i < NP; i++) begin
            step(1'b0, '0, '0, 1'b1);
            check({tag, "_valid"},  b_valid, 1'b1);
            check({tag, "_last"},   b_last, i == NP - 1);
            check({tag, "_br_1"},   b_1r, base + lit_b1[i]);
            check({tag, "_br_2"},   b_2r, base + lit_b2[i]);
            check({tag, "_br_2i"},  b_2i, base + lit_b2[i] + 8);
            check({tag, "_lin_1"},  l_1r, base + lit_l1[i]);
            check({tag, "_lin_2"},  l_2r, base + lit_l2[i]);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;

        // Single frame, both address orders
        write_frame(0);
        check("t1_frames", b_fr, 2'd1);
        read_frame_literal(0, "t1");
        check("t1_empty_after", b_empty, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        check("t1_idle_valid", b_valid, 1'b0);

        // Fill both banks, then an ignored write
        for (int k = 0; k < 2 * N; k++) begin
            step(1'b1, 16'(16 + k), 16'(24 + k), 1'b0);
            if (k == N - 1) check("t3_frames_1", b_fr, 2'd1);
        end
        check("t3_frames_2", b_fr, 2'd2);
        check("t3_full", b_full, 1'b1);
        step(1'b1, 16'hdead, 16'hbeef, 1'b0);
        check("t3_ignored_frames", b_fr, 2'd2);
        step(1'b0, '0, '0, 1'b1);
        check("t3_frame0_1", b_1r, 16'd16);
        check("t3_frame0_2", b_2r, 16'd20);
        for (int i = 1; i < 2 * NP; i++) step(1'b0, '0, '0, 1'b1);
        check("t3_drained", b_fr, 2'd0);

        // Read on empty, and read colliding with frame close
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        check("t6_empty_read", b_valid, 1'b0);
        for (int k = 0; k < N - 1; k++) step(1'b1, 16'(50 + k), 16'(58 + k), 1'b0);
        step(1'b1, 16'd57, 16'd65, 1'b1);
        check("t6_close_valid", b_valid, 1'b0);
        check("t6_close_empty", b_empty, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        check("t6_next_valid", b_valid, 1'b1);
        check("t6_next_data", b_1r, 16'd50);
        for (int i = 1; i < NP; i++) step(1'b0, '0, '0, 1'b1);

        // Steady stream: writer never stalls
        for (int c = 0; c < 160; c++) begin
            step(1'b1, 16'($urandom), 16'($urandom), !b_empty);
            check("t4_never_full", b_full, 1'b0);
        end

        // Random traffic: read-starved first, then read-heavy
        for (int c = 0; c < 800; c++) begin
            if (c < 400) step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                              $urandom_range(0, 3) == 0);
            else         step($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom),
                              $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-frame
        pulse_reset();
        write_frame(60);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 16'(90 + k), 16'(98 + k), 1'b0);
        #2 RST = 1'b0;
        #1 check_reset_outputs("t5_async");
        @(negedge CLK);
        RST = 1'b1;
        write_frame(70);
        check("t5_frames", b_fr, 2'd1);
        read_frame_literal(70, "t5");
        step(1'b0, '0, '0, 1'b0);
        check("t5_empty_after", b_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
